// File: rtl/msg_sender_pkg.sv
// Shared message codes and FSM encoding for the multiplayer UART link.
package msg_sender_pkg;

  // Message bytes shared with the receive-side decoder
  localparam logic [7:0] MSG_READY = 8'h52;  // 'R'
  localparam logic [7:0] MSG_LOST  = 8'h4C;  // 'L'
  localparam logic [7:0] MSG_NONE  = 8'h00;

  localparam int unsigned REP_W = 4;
  localparam int unsigned GAP_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/msg_gap_timer.sv
// Loadable down-counter timing the idle interval between two writes.
module msg_gap_timer
  import msg_sender_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic done_c
);

  // Loaded with GAP_CYCLES-1 so done_c rises on the last gap cycle
  localparam logic [GAP_W-1:0] LOAD_VAL = GAP_W'(GAP_CYCLES - 1);

  logic [GAP_W-1:0] count_q;

  // Count down to zero after each load, then hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= LOAD_VAL;
    end else if (count_q != '0) begin
      count_q <= count_q - GAP_W'(1);
    end
  end

  assign done_c = (count_q == '0);

endmodule

// File: rtl/msg_sender.sv
// Encodes local game events into repeated ASCII bytes for the UART TX FIFO.
module msg_sender
  import msg_sender_pkg::*;
#(
  parameter int unsigned REPEAT     = 3,
  parameter int unsigned GAP_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       multiplayer,
  input  logic       play_selected,
  input  logic       player_lost,
  input  logic       tx_full,
  output logic       wr_uart,
  output logic [7:0] w_data,
  output logic       busy
);

  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT);

  state_t           state_q, state_d;
  logic             pend_r_q, pend_r_d;
  logic             pend_l_q, pend_l_d;
  logic             play_prev_q;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [7:0]       data_q, data_d;
  logic             wr_d;
  logic             busy_d;
  logic             set_r, set_l, clr_r, clr_l;
  logic             gap_load, gap_done_c;

  msg_gap_timer #(
    .GAP_CYCLES(GAP_CYCLES)
  ) u_gap_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (gap_load),
    .done_c (gap_done_c)
  );

  // Next-state, request bookkeeping and output decode
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    rep_d    = rep_q;
    wr_d     = 1'b0;
    gap_load = 1'b0;
    clr_r    = 1'b0;
    clr_l    = 1'b0;

    set_r = multiplayer & play_selected & ~play_prev_q;
    set_l = multiplayer & player_lost;

    case (state_q)
      ST_IDLE: begin
        if (pend_l_q) begin
          // A lost round supersedes any ready request still waiting
          data_d  = MSG_LOST;
          rep_d   = '0;
          clr_l   = 1'b1;
          clr_r   = 1'b1;
          state_d = ST_SEND;
        end else if (pend_r_q) begin
          data_d  = MSG_READY;
          rep_d   = '0;
          clr_r   = 1'b1;
          state_d = ST_SEND;
        end
      end

      ST_SEND: begin
        if (!multiplayer) begin
          state_d = ST_IDLE;
        end else if (!tx_full) begin
          wr_d     = 1'b1;
          rep_d    = rep_q + REP_W'(1);
          gap_load = 1'b1;
          state_d  = ST_GAP;
        end
      end

      ST_GAP: begin
        if (gap_done_c) begin
          if (!multiplayer) begin
            state_d = ST_IDLE;
          end else if (pend_l_q && (data_q == MSG_READY)) begin
            // Abandon remaining ready repeats and report the loss now
            data_d  = MSG_LOST;
            rep_d   = '0;
            clr_l   = 1'b1;
            clr_r   = 1'b1;
            state_d = ST_SEND;
          end else if (rep_q == REP_LAST) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_SEND;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A new request wins over a same-cycle clear; leaving multiplayer drops all
    pend_r_d = multiplayer & (set_r | (pend_r_q & ~clr_r));
    pend_l_d = multiplayer & (set_l | (pend_l_q & ~clr_l));

    busy_d = (state_d != ST_IDLE) | pend_r_d | pend_l_d;
  end

  // State, request flags and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      pend_r_q    <= 1'b0;
      pend_l_q    <= 1'b0;
      play_prev_q <= 1'b0;
      rep_q       <= '0;
      data_q      <= MSG_NONE;
      wr_uart     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_r_q    <= pend_r_d;
      pend_l_q    <= pend_l_d;
      play_prev_q <= play_selected;
      rep_q       <= rep_d;
      data_q      <= data_d;
      wr_uart     <= wr_d;
      busy        <= busy_d;
    end
  end

  assign w_data = data_q;

endmodule

// File: tb/tb_msg_sender.sv
// Directed bench for msg_sender: scenario table plus reset corner sequences.
module tb_msg_sender;

  localparam int unsigned REPEAT = 3;
  localparam int unsigned GAP    = 16;
  localparam int          MAXW   = 6;
  localparam int          NSCN   = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       multiplayer;
  logic       play_selected;
  logic       player_lost;
  logic       tx_full;
  logic       wr_uart;
  logic [7:0] w_data;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  msg_sender #(
    .REPEAT     (REPEAT),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .multiplayer   (multiplayer),
    .play_selected (play_selected),
    .player_lost   (player_lost),
    .tx_full       (tx_full),
    .wr_uart       (wr_uart),
    .w_data        (w_data),
    .busy          (busy)
  );

  // One scenario: input schedule (cycle indices, -1 = never) and expected writes
  typedef struct {
    string                  name;
    logic                   mp;
    int                     play_at;
    int                     lost_at;
    int                     lost2_at;
    int                     mp_off;
    int                     full_from;
    int                     full_to;
    int                     win;
    int                     exp_n;
    logic [MAXW-1:0][7:0]   exp_b;
    logic [MAXW-1:0][15:0]  exp_c;
  } scn_t;

  scn_t scn [NSCN];

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b0;
    multiplayer   = 1'b0;
    play_selected = 1'b0;
    player_lost   = 1'b0;
    tx_full       = 1'b0;
    repeat (3) step();
    rst = 1'b1;
  endtask

  // Apply one scenario; output index is the edge count after reset release
  task automatic run_scn(input scn_t s);
    int         n;
    int         bad_full;
    logic [7:0] got_b [MAXW];
    int         got_c [MAXW];
    for (int i = 0; i < MAXW; i++) begin
      got_b[i] = 8'h00;
      got_c[i] = -1;
    end
    do_reset();
    n        = 0;
    bad_full = 0;
    for (int t = 0; t < s.win; t++) begin
      multiplayer   = s.mp && (t < s.mp_off);
      play_selected = (s.play_at >= 0) && (t >= s.play_at);
      player_lost   = (t == s.lost_at) || (t == s.lost2_at);
      tx_full       = (t >= s.full_from) && (t < s.full_to);
      step();
      if (wr_uart) begin
        if (tx_full) bad_full++;
        if (n < MAXW) begin
          got_b[n] = w_data;
          got_c[n] = t + 1;
        end
        n++;
      end
    end
    check({s.name, " write count"}, n, s.exp_n);
    for (int i = 0; i < s.exp_n; i++) begin
      check($sformatf("%s byte %0d", s.name, i), int'(got_b[i]), int'(s.exp_b[i]));
      check($sformatf("%s cycle %0d", s.name, i), got_c[i], int'(s.exp_c[i]));
    end
    check({s.name, " busy at end"}, int'(busy), 0);
    check({s.name, " writes while full"}, bad_full, 0);
  endtask

  initial begin
    int n;
    int seen;

    rst           = 1'b1;
    multiplayer   = 1'b0;
    play_selected = 1'b0;
    player_lost   = 1'b0;
    tx_full       = 1'b0;

    scn[0] = '{"ready", 1'b1, 10, -1, -1, 9999, -1, -1, 100, 3,
               {8'h00, 8'h00, 8'h00, 8'h52, 8'h52, 8'h52},
               {16'd0, 16'd0, 16'd0, 16'd47, 16'd30, 16'd13}};
    scn[1] = '{"lost", 1'b1, -1, 10, -1, 9999, -1, -1, 100, 3,
               {8'h00, 8'h00, 8'h00, 8'h4C, 8'h4C, 8'h4C},
               {16'd0, 16'd0, 16'd0, 16'd47, 16'd30, 16'd13}};
    scn[2] = '{"single_player", 1'b0, 5, 10, -1, 9999, -1, -1, 80, 0,
               {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
               {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}};
    scn[3] = '{"backpressure", 1'b1, 10, -1, -1, 9999, 0, 32, 110, 3,
               {8'h00, 8'h00, 8'h00, 8'h52, 8'h52, 8'h52},
               {16'd0, 16'd0, 16'd0, 16'd67, 16'd50, 16'd33}};
    scn[4] = '{"preempt", 1'b1, 10, 20, -1, 9999, -1, -1, 130, 4,
               {8'h00, 8'h00, 8'h4C, 8'h4C, 8'h4C, 8'h52},
               {16'd0, 16'd0, 16'd64, 16'd47, 16'd30, 16'd13}};
    scn[5] = '{"simultaneous", 1'b1, 10, 10, -1, 9999, -1, -1, 100, 3,
               {8'h00, 8'h00, 8'h00, 8'h4C, 8'h4C, 8'h4C},
               {16'd0, 16'd0, 16'd0, 16'd47, 16'd30, 16'd13}};
    scn[6] = '{"mp_drop_in_gap", 1'b1, 10, -1, -1, 20, -1, -1, 100, 1,
               {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h52},
               {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd13}};
    scn[7] = '{"lost_twice", 1'b1, -1, 10, 20, 9999, -1, -1, 130, 6,
               {8'h4C, 8'h4C, 8'h4C, 8'h4C, 8'h4C, 8'h4C},
               {16'd99, 16'd82, 16'd65, 16'd47, 16'd30, 16'd13}};

    // Held in reset with arbitrary inputs: outputs stay at reset values
    #2 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      multiplayer   = 1'($urandom);
      play_selected = 1'($urandom);
      player_lost   = 1'($urandom);
      tx_full       = 1'($urandom);
      step();
      check($sformatf("reset wr_uart %0d", i), int'(wr_uart), 0);
      check($sformatf("reset w_data %0d", i), int'(w_data), 0);
      check($sformatf("reset busy %0d", i), int'(busy), 0);
    end

    for (int k = 0; k < NSCN; k++) run_scn(scn[k]);

    // Asynchronous reset while a ready write is on the port
    do_reset();
    multiplayer = 1'b1;
    step();
    play_selected = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      step();
      if (wr_uart) seen = 1;
    end
    check("async reset: write reached", seen, 1);
    check("async reset: byte before", int'(w_data), 32'h52);
    #2 rst = 1'b0;
    #1;
    check("async reset: wr_uart", int'(wr_uart), 0);
    check("async reset: w_data", int'(w_data), 0);
    check("async reset: busy", int'(busy), 0);
    play_selected = 1'b0;
    step();
    step();
    rst = 1'b1;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (wr_uart) n++;
    end
    check("async reset: no resume", n, 0);
    check("async reset: idle busy", int'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Guard against a stuck simulation
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
